dvp_pattern_gen: RTL

- Synthesizable DVP-style camera source: emits frame-valid, line-valid and pixel data in the same format the Himax sensor drives into the vision front end. Supports 8-bit or 4-bit nibble mode.
- Used on-chip as a loopback/test-pattern source for the pixel capture path, and as the drive end for bring-up without a sensor fitted.
- Generates deterministic patterns so a capture block downstream can be checked pixel-for-pixel.

---
 rtl/dvp_pattern_gen.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/dvp_pattern_gen.sv
// dvp_pattern_gen
//   DVP-style camera source. Emits frame-valid, line-valid and pixel data with
//   the framing a Himax sensor drives into the vision front end, carrying one
//   of four deterministic patterns so a downstream capture block can be
//   checked pixel-for-pixel. Every output is registered.
//
//   Ports
//     clk          pixel clock, rising edge
//     rst_n        asynchronous active-low reset
//     start        request one frame (sampled only while idle)
//     continuous   free-run frames back-to-back (sampled at end of vertical blank)
//     pattern_sel  0 pixel index, 1 const_val, 2 col^row, 3 checkerboard
//     const_val    value for pattern 1 (latched at frame start)
//     px_fv        frame valid
//     px_lv        line valid
//     pxd          pixel data; in nibble mode only [3:0] is used, upper nibble first
//     busy         high whenever the generator is not idle
//     frame_done   one-cycle pulse on the cycle px_fv falls
//     frame_cnt    completed frames, wrapping
//
//   Nibble mode (FOUR_BITS = 1) sends bits [7:4] then [3:0] of each pixel and
//   therefore expects WIDTH >= 8.
module dvp_pattern_gen #(
   parameter int WIDTH     = 8,
   parameter int FOUR_BITS = 1,
   parameter int NUM_COLS  = 40,
   parameter int NUM_ROWS  = 30,
   parameter int HOR_BLANK = 4,
   parameter int FV_LEAD   = 2,
   parameter int FV_TRAIL  = 2,
   parameter int VER_BLANK = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             continuous,
   input  logic [1:0]       pattern_sel,
   input  logic [WIDTH-1:0] const_val,
   output logic             px_fv,
   output logic             px_lv,
   output logic [WIDTH-1:0] pxd,
   output logic             busy,
   output logic             frame_done,
   output logic [15:0]      frame_cnt
);

   localparam int COL_W   = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
   localparam int ROW_W   = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
   localparam int MAX_A   = (HOR_BLANK > FV_LEAD) ? HOR_BLANK : FV_LEAD;
   localparam int MAX_B   = (FV_TRAIL > VER_BLANK) ? FV_TRAIL : VER_BLANK;
   localparam int BLK_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int BLK_W   = (BLK_MAX > 1) ? $clog2(BLK_MAX) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_LEAD, S_LINE, S_HBLANK, S_TRAIL, S_VBLANK
   } state_t;

   // Terminal count of a blanking interval of n cycles. For n = 0 the state
   // is never entered, so the wrapped value is never compared.
   function automatic logic [BLK_W-1:0] last_cnt(input int n);
      return BLK_W'(n - 1);
   endfunction

   state_t           state_q, state_d;
   logic [BLK_W-1:0] cnt_q, cnt_d;
   logic [COL_W-1:0] col_q, col_d;
   logic [ROW_W-1:0] row_q, row_d;
   logic             beat_q, beat_d;
   logic [WIDTH-1:0] pix_q, pix_d;      // frame pixel index, wraps at 2^WIDTH
   logic [1:0]       pat_q, pat_d;
   logic [WIDTH-1:0] const_q, const_d;
   logic             new_frame, frame_over;

   logic             fv_d, lv_d, busy_d;
   logic [WIDTH-1:0] pix_val, pxd_d;

   // Next-state and counter logic.
   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path through
      // the case leaves one unassigned and infers a latch.
      state_d    = state_q;
      cnt_d      = cnt_q;
      col_d      = col_q;
      row_d      = row_q;
      beat_d     = beat_q;
      pix_d      = pix_q;
      pat_d      = pat_q;
      const_d    = const_q;
      new_frame  = 1'b0;
      frame_over = 1'b0;

      case (state_q)
         S_IDLE: new_frame = start | continuous;
         S_LEAD: begin
            if (cnt_q == last_cnt(FV_LEAD)) state_d = S_LINE;
            else                            cnt_d   = cnt_q + 1'b1;
         end
         S_LINE: begin
            if ((FOUR_BITS != 0) && !beat_q) begin
               beat_d = 1'b1;
            end else begin
               beat_d = 1'b0;
               pix_d  = pix_q + 1'b1;
               if (col_q != COL_W'(NUM_COLS - 1)) begin
                  col_d = col_q + 1'b1;
               end else begin
                  col_d = '0;
                  if (row_q != ROW_W'(NUM_ROWS - 1)) begin
                     if (HOR_BLANK > 0) state_d = S_HBLANK;
                     else               row_d   = row_q + 1'b1;
                  end else if (FV_TRAIL > 0) begin
                     state_d = S_TRAIL;
                  end else begin
                     frame_over = 1'b1;
                  end
               end
            end
         end
         S_HBLANK: begin
            if (cnt_q == last_cnt(HOR_BLANK)) begin
               state_d = S_LINE;
               row_d   = row_q + 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_TRAIL: begin
            if (cnt_q == last_cnt(FV_TRAIL)) frame_over = 1'b1;
            else                             cnt_d      = cnt_q + 1'b1;
         end
         S_VBLANK: begin
            if (cnt_q == last_cnt(VER_BLANK)) begin
               if (continuous) new_frame = 1'b1;
               else            state_d   = S_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Leaving the last FV-high state: blank if configured, else decide now.
      if (frame_over) begin
         if (VER_BLANK > 0)   state_d   = S_VBLANK;
         else if (continuous) new_frame = 1'b1;
         else                 state_d   = S_IDLE;
      end

      // Frame start: pattern settings are frozen here for the whole frame.
      if (new_frame) begin
         state_d = (FV_LEAD > 0) ? S_LEAD : S_LINE;
         col_d   = '0;
         row_d   = '0;
         beat_d  = 1'b0;
         pix_d   = '0;
         pat_d   = pattern_sel;
         const_d = const_val;
      end

      if (state_d != state_q) cnt_d = '0;
   end

   // Output values for the next cycle, derived from the next state so the
   // registered outputs line up with the state they describe.
   always_comb begin
      fv_d   = state_d inside {S_LEAD, S_LINE, S_HBLANK, S_TRAIL};
      lv_d   = (state_d == S_LINE);
      busy_d = (state_d != S_IDLE);

      case (pat_d)
         2'd0:    pix_val = pix_d;
         2'd1:    pix_val = const_d;
         2'd2:    pix_val = WIDTH'(col_d) ^ WIDTH'(row_d);
         default: pix_val = {WIDTH{col_d[0] ^ row_d[0]}};
      endcase

      pxd_d = '0;
      if (lv_d) begin
         if (FOUR_BITS != 0) pxd_d = WIDTH'(beat_d ? pix_val[3:0] : pix_val[7:4]);
         else                pxd_d = pix_val;
      end
   end

   // State, counters and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: every register, latched pattern settings included, is cleared so an
         // aborted frame leaves nothing behind for the next one.
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         col_q      <= '0;
         row_q      <= '0;
         beat_q     <= 1'b0;
         pix_q      <= '0;
         pat_q      <= '0;
         const_q    <= '0;
         px_fv      <= 1'b0;
         px_lv      <= 1'b0;
         pxd        <= '0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         frame_cnt  <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the values
         // from before this edge, independent of statement order.
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         col_q      <= col_d;
         row_q      <= row_d;
         beat_q     <= beat_d;
         pix_q      <= pix_d;
         pat_q      <= pat_d;
         const_q    <= const_d;
         px_fv      <= fv_d;
         px_lv      <= lv_d;
         pxd        <= pxd_d;
         busy       <= busy_d;
         frame_done <= frame_over;
         if (frame_over) frame_cnt <= frame_cnt + 1'b1;
      end
   end

endmodule
